sdram_cmd_arbiter: RTL and testbench

Top-level sequencer for the SDRAM controller's command-generator FSMs (init, auto-refresh, burst read w/ auto-precharge, burst write w/ auto-precharge). It arbitrates between host read/write requests and an internal periodic refresh timer. It drives the start/done handshake of exactly one generator at a time and muxes that generator's 4-bit command and data-phase enable onto the SDRAM side.

---
 rtl/sdram_cmd_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_sdram_cmd_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_arbiter.sv
// Sequences the SDRAM command generators (init, refresh, read, write),
// arbitrating host requests against a periodic refresh timer.
module sdram_cmd_arbiter #(
    parameter int unsigned REF_PERIOD = 780
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rd_req,
    input  logic       wr_req,
    output logic       rd_ack,
    output logic       wr_ack,
    output logic       ready,
    output logic       ref_late,
    output logic       start_init,
    output logic       start_ref,
    output logic       start_rd,
    output logic       start_wr,
    input  logic       done_init,
    input  logic       done_ref,
    input  logic       done_rd,
    input  logic       done_wr,
    input  logic [3:0] cmd_init,
    input  logic [3:0] cmd_ref,
    input  logic [3:0] cmd_rd,
    input  logic [3:0] cmd_wr,
    input  logic       chip_rd,
    input  logic       chip_wr,
    output logic [3:0] command,
    output logic       rd_data_en,
    output logic       wr_data_en
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_IDLE,
        S_SERVE,
        S_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        G_INIT,
        G_REF,
        G_RD,
        G_WR
    } grant_t;

    localparam logic [15:0] RELOAD = 16'(REF_PERIOD - 1);

    state_t      state_q, state_d;
    grant_t      grant_q, grant_d;
    logic        last_wr_q, last_wr_d;
    logic        ready_q, ready_d;
    logic        rd_ack_q, rd_ack_d;
    logic        wr_ack_q, wr_ack_d;
    logic        pend_q, pend_d;
    logic        late_q, late_d;
    logic [15:0] cnt_q, cnt_d;

    logic done_g;
    logic ref_clr;
    logic expire;
    logic active;

    always_comb begin
        done_g = 1'b0;
        case (grant_q)
            G_INIT:  done_g = done_init;
            G_REF:   done_g = done_ref;
            G_RD:    done_g = done_rd;
            G_WR:    done_g = done_wr;
            default: done_g = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_wr_d = last_wr_q;
        ready_d   = ready_q;
        rd_ack_d  = 1'b0;
        wr_ack_d  = 1'b0;
        ref_clr   = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_SERVE;
                grant_d = G_INIT;
            end
            S_IDLE: begin
                // Refresh outranks host; on a tie alternate against last_rw.
                if (pend_q) begin
                    state_d = S_SERVE;
                    grant_d = G_REF;
                end else if (rd_req && (!wr_req || last_wr_q)) begin
                    state_d   = S_SERVE;
                    grant_d   = G_RD;
                    last_wr_d = 1'b0;
                end else if (wr_req) begin
                    state_d   = S_SERVE;
                    grant_d   = G_WR;
                    last_wr_d = 1'b1;
                end
            end
            S_SERVE: begin
                if (done_g) begin
                    state_d  = S_RELEASE;
                    ready_d  = ready_q | (grant_q == G_INIT);
                    ref_clr  = (grant_q == G_REF);
                    rd_ack_d = (grant_q == G_RD);
                    wr_ack_d = (grant_q == G_WR);
                end
            end
            S_RELEASE: begin
                if (!done_g) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    assign expire = ready_q && (cnt_q == 16'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (!ready_q) begin
            if (ready_d) begin
                cnt_d = RELOAD;
            end
        end else if (expire) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    // An expiry wins over a same-cycle clear so no refresh is lost.
    assign pend_d = expire | (pend_q & ~ref_clr);
    assign late_d = late_q | (expire & pend_q);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_BOOT;
            grant_q   <= G_INIT;
            last_wr_q <= 1'b1;
            ready_q   <= 1'b0;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            pend_q    <= 1'b0;
            late_q    <= 1'b0;
            cnt_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_wr_q <= last_wr_d;
            ready_q   <= ready_d;
            rd_ack_q  <= rd_ack_d;
            wr_ack_q  <= wr_ack_d;
            pend_q    <= pend_d;
            late_q    <= late_d;
            cnt_q     <= cnt_d;
        end
    end

    assign active = (state_q == S_SERVE) || (state_q == S_RELEASE);

    assign start_init = (state_q == S_SERVE) && (grant_q == G_INIT);
    assign start_ref  = (state_q == S_SERVE) && (grant_q == G_REF);
    assign start_rd   = (state_q == S_SERVE) && (grant_q == G_RD);
    assign start_wr   = (state_q == S_SERVE) && (grant_q == G_WR);

    always_comb begin
        command = 4'd0;
        if (active) begin
            case (grant_q)
                G_INIT:  command = cmd_init;
                G_REF:   command = cmd_ref;
                G_RD:    command = cmd_rd;
                G_WR:    command = cmd_wr;
                default: command = 4'd0;
            endcase
        end
    end

    assign rd_data_en = active && (grant_q == G_RD) && chip_rd;
    assign wr_data_en = active && (grant_q == G_WR) && chip_wr;

    assign rd_ack   = rd_ack_q;
    assign wr_ack   = wr_ack_q;
    assign ready    = ready_q;
    assign ref_late = late_q;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter with simple generator models
// (init 20, refresh 3, read 9, write 45 cycles from start to done).
module tb_sdram_cmd_arbiter;

    localparam int P      = 20;
    localparam int D_INIT = 20;
    localparam int D_REF  = 3;
    localparam int D_RD   = 9;
    localparam int D_WR   = 45;

    localparam logic [3:0] C_INIT = 4'h1;
    localparam logic [3:0] C_REF  = 4'h2;
    localparam logic [3:0] C_RD   = 4'h5;
    localparam logic [3:0] C_WR   = 4'h4;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       rd_req, wr_req;
    logic       rd_ack, wr_ack, ready, ref_late;
    logic       start_init, start_ref, start_rd, start_wr;
    logic       done_init, done_ref, done_rd, done_wr;
    logic [3:0] cmd_init, cmd_ref, cmd_rd, cmd_wr;
    logic       chip_rd, chip_wr;
    logic [3:0] command;
    logic       rd_data_en, wr_data_en;
    logic       any_start;

    int c_init, c_ref, c_rd, c_wr;
    int n_asrt = 0;
    int n_fail = 0;

    assign cmd_init  = C_INIT;
    assign cmd_ref   = C_REF;
    assign cmd_rd    = C_RD;
    assign cmd_wr    = C_WR;
    assign any_start = start_init | start_ref | start_rd | start_wr;

    always #5 clk = ~clk;

    sdram_cmd_arbiter #(.REF_PERIOD(P)) dut (
        .clk(clk), .n_rst(n_rst),
        .rd_req(rd_req), .wr_req(wr_req),
        .rd_ack(rd_ack), .wr_ack(wr_ack),
        .ready(ready), .ref_late(ref_late),
        .start_init(start_init), .start_ref(start_ref),
        .start_rd(start_rd), .start_wr(start_wr),
        .done_init(done_init), .done_ref(done_ref),
        .done_rd(done_rd), .done_wr(done_wr),
        .cmd_init(cmd_init), .cmd_ref(cmd_ref),
        .cmd_rd(cmd_rd), .cmd_wr(cmd_wr),
        .chip_rd(chip_rd), .chip_wr(chip_wr),
        .command(command),
        .rd_data_en(rd_data_en), .wr_data_en(wr_data_en)
    );

    // Generator models: done rises D cycles after start, falls once start drops.
    always @(posedge clk or negedge n_rst)
        if (!n_rst) begin done_init <= 0; c_init <= 0; end
        else if (!start_init) begin done_init <= 0; c_init <= 0; end
        else if (!done_init) begin
            if (c_init == D_INIT - 1) done_init <= 1;
            else c_init <= c_init + 1;
        end

    always @(posedge clk or negedge n_rst)
        if (!n_rst) begin done_ref <= 0; c_ref <= 0; end
        else if (!start_ref) begin done_ref <= 0; c_ref <= 0; end
        else if (!done_ref) begin
            if (c_ref == D_REF - 1) done_ref <= 1;
            else c_ref <= c_ref + 1;
        end

    always @(posedge clk or negedge n_rst)
        if (!n_rst) begin done_rd <= 0; c_rd <= 0; end
        else if (!start_rd) begin done_rd <= 0; c_rd <= 0; end
        else if (!done_rd) begin
            if (c_rd == D_RD - 1) done_rd <= 1;
            else c_rd <= c_rd + 1;
        end

    always @(posedge clk or negedge n_rst)
        if (!n_rst) begin done_wr <= 0; c_wr <= 0; end
        else if (!start_wr) begin done_wr <= 0; c_wr <= 0; end
        else if (!done_wr) begin
            if (c_wr == D_WR - 1) done_wr <= 1;
            else c_wr <= c_wr + 1;
        end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        while (!any_start && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (any_start && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n, a, b, hi, host, code;
        logic early, cbad;
        int exp_seq[4];
        exp_seq = '{2, 3, 2, 3};

        n_rst = 0; rd_req = 0; wr_req = 0; chip_rd = 0; chip_wr = 0;
        step(2);
        check("rst_starts", any_start, 0);
        check("rst_cmd", command, 0);
        check("rst_ready", ready, 0);
        check("rst_late", ref_late, 0);
        check("rst_acks", {rd_ack, wr_ack}, 0);

        // Init sequence
        n_rst = 1;
        step(1);
        check("init_start_cyc1", start_init, 1);
        check("init_cmd", command, C_INIT);
        hi = 0; early = 0; cbad = 0;
        while (start_init && hi < 100) begin
            hi++;
            if (ready !== 1'b0) early = 1;
            if (command !== C_INIT) cbad = 1;
            step(1);
        end
        check("init_start_len", hi, D_INIT + 1);
        check("init_ready_early", early, 0);
        check("init_cmd_serve", cbad, 0);
        check("init_ready_set", ready, 1);
        check("init_rel_cmd0", command, C_INIT);
        step(1);
        check("init_rel_cmd1", command, C_INIT);
        step(1);
        check("idle_cmd", command, 0);

        // Single read
        rd_req = 1;
        step(1);
        check("rd_start", start_rd, 1);
        check("rd_cmd", command, C_RD);
        check("rd_den_off", rd_data_en, 0);
        chip_rd = 1; chip_wr = 1;
        #1;
        check("rd_den_on", rd_data_en, 1);
        check("rd_wden_gated", wr_data_en, 0);
        chip_wr = 0;
        n = 0;
        while (!rd_ack && n < 50) begin step(1); n++; end
        check("rd_ack", rd_ack, 1);
        check("rd_ack_lat", n, D_RD + 1);
        check("rd_rel_start", start_rd, 0);
        check("rd_rel_cmd", command, C_RD);
        rd_req = 0;
        step(1);
        check("rd_ack_once", rd_ack, 0);
        step(1);
        check("rd_idle_cmd", command, 0);
        check("rd_idle_den", rd_data_en, 0);
        chip_rd = 0;

        // Periodic refresh, no host traffic
        wait_rise(n);
        check("ref_first", start_ref, 1);
        check("ref_first_lat", n, 6);
        check("ref_cmd", command, C_REF);
        wait_fall(a); wait_rise(b);
        check("ref_period1", a + b, P);
        wait_fall(a); wait_rise(b);
        check("ref_period2", a + b, P);
        check("ref_late_quiet", ref_late, 0);

        // Long write makes refresh late; REF beats queued read
        n_rst = 0; step(2); n_rst = 1;
        wait_rise(n);
        check("init2_start", start_init, 1);
        wait_fall(n);
        wr_req = 1;
        n = 0;
        while (!wr_ack && n < 200) begin step(1); n++; end
        check("wr_ack", wr_ack, 1);
        check("wr_late", ref_late, 1);
        wr_req = 0; rd_req = 1;
        wait_rise(n);
        check("ref_prio_ref", start_ref, 1);
        check("ref_prio_rd", start_rd, 0);
        check("ref_prio_gap", n, 3);
        wait_fall(n);
        wait_rise(n);
        check("rd_after_ref", start_rd, 1);

        // Asynchronous reset mid read
        step(2);
        chip_rd = 1;
        n_rst = 0;
        #1;
        check("arst_starts", any_start, 0);
        check("arst_cmd", command, 0);
        check("arst_den", rd_data_en, 0);
        check("arst_ready", ready, 0);
        check("arst_late", ref_late, 0);
        chip_rd = 0;
        step(1);
        n_rst = 1;
        #1;
        check("arst_boot", start_init, 0);
        step(1);
        check("arst_init", start_init, 1);
        check("arst_ready_lo", ready, 0);
        wait_fall(n);
        check("arst_ready_hi", ready, 1);

        // Simultaneous rd/wr: alternate, starting with read
        rd_req = 1; wr_req = 1;
        host = 0;
        for (int k = 0; k < 10 && host < 4; k++) begin
            wait_rise(n);
            check("tie_gap", n, 3);
            code = start_rd ? 2 : (start_wr ? 3 : (start_ref ? 1 : 0));
            if (code >= 2) begin
                check("tie_order", code, exp_seq[host]);
                host++;
                if (host == 4) begin rd_req = 0; wr_req = 0; end
            end
            wait_fall(n);
        end
        check("tie_count", host, 4);

        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
